sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Arbitrates the single external 256K×16 asynchronous SRAM between three 32-bit requesters: VGA frame reader (port 0), instruction fetch (port 1) and data memory (port 2). Each 32-bit word is transferred as two sequenced 16-bit SRAM cycles, low half first. The block sits between the processor's two memory buses and the board SRAM pins.

## Interface
- AW, default 17: word address width; SRAM address is {addr, half}, AW+1 bits.
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset; one clock, reset is synchronous and active-low.
- p0_req  in  1  VGA read request; p0_addr  in  AW  word address.
- p1_req  in  1  instruction read request; p1_addr  in  AW.
- p2_req  in  1  data request; p2_addr  in  AW; p2_we  in  1  write when 1; p2_wdata  in  32; p2_be  in  4  byte enables, bit 0 = bits 7:0.
- p0_ack, p1_ack, p2_ack  out  1 each  one-cycle completion pulse.
- rdata  out  32  read data, valid in the ack cycle, held until the next read completes.
- SRAM_ADDR  out  AW+1; SRAM_DQ  inout  16.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each, active-low strobes.

## Operation
- Requesters hold req, addr, we, wdata, be stable from assertion until their ack; dropping req mid-transaction does not abort it; ack is still issued.
- States: IDLE, LO, HI, DONE. All outputs registered.
- IDLE: if any req, grant one port and go to LO; else stay.
- Priority: p0 highest (display must not underrun); then between p1 and p2 per Configuration.
- LO: SRAM_ADDR = {addr,0}, CE_N=0. Read: OE_N=0, UB_N=LB_N=0, DQ tri-stated. Write: OE_N=1, WE_N=0, DQ driven with wdata[15:0], UB_N=~be[1], LB_N=~be[0].
- HI: SRAM_ADDR = {addr,1}; read captures DQ into rdata[15:0]; write drives wdata[31:16], UB_N=~be[3], LB_N=~be[2].
- DONE: read captures DQ into rdata[31:16]; granted port's ack = 1; all strobes high, DQ tri-stated; next state IDLE.
- be = 0000 on a write: full sequence still runs with UB_N=LB_N=1 (no byte written), ack issued.
- Only one ack high in any cycle; rdata changes only on read completion.
- p1 never writes; p0 and p1 accesses are always reads.

## Timing
- Reset (rst=0 at a clock edge): state IDLE, all acks 0, rdata 0, SRAM_ADDR 0, CE_N/OE_N/WE_N/UB_N/LB_N = 1, DQ tri-stated. Reset mid-transaction abandons it without ack; a partial write may have occurred.
- req sampled high in IDLE at edge N: LO during cycle N+1, HI during N+2, DONE (ack) during N+3, IDLE from N+4.
- Fixed 4-cycle occupancy per access; sustained throughput one word per 4 cycles.
- Request arriving while busy waits; it is evaluated in the IDLE cycle after DONE.
- Simultaneous requests are resolved in a single IDLE cycle; losers keep req high and are served later.
- WE_N is low for exactly one cycle per half, with address and data changing on the same edge as WE_N.

## Configuration
- SRAM_ARB_RR_EN defined: p1/p2 contention is round-robin. A one-bit last-winner register is updated on each p1/p2 grant; when both request, the port not granted last wins; reset value favours p2.
- Undefined: fixed priority p0 > p2 > p1.
- p0 is always highest in both builds.

## Test plan
- Reset: rst=0 for 2 cycles mid-write -> all strobes 1, acks 0, rdata 0; first request after reset acks at N+3.
- p2 write addr 0x00010, wdata 0xDEADBEEF, be 1111, then p1 read 0x00010 -> SRAM halfwords 0x00020=0xBEEF, 0x00021=0xDEAD; p1_ack with rdata 0xDEADBEEF.
- p2 write be 0100 wdata 0x00AA0000 over 0xDEADBEEF -> readback 0xDEAABEEF; be 0000 -> data unchanged, p2_ack still issued.
- p0, p1, p2 requested in the same cycle -> p0_ack at N+3, then grants per macro; no two acks coincident.
- p1 and p2 held high for 8 grants: SRAM_ARB_RR_EN -> strictly alternating acks starting with p2; undefined -> p2 every time, p1 starved.
- p1 req dropped after one cycle -> p1_ack still pulses at N+3; no extra access follows.

Source files
------------

// File: rtl/sram_arbiter.sv
// Three-port arbiter for a 256Kx16 asynchronous SRAM; each 32-bit word moves as two 16-bit halves, low first.
// Optional macro SRAM_ARB_RR_EN: round-robin between p1 and p2 (default fixed priority p0 > p2 > p1).
module sram_arbiter #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  input  logic          p1_req,
  input  logic [AW-1:0] p1_addr,
  input  logic          p2_req,
  input  logic [AW-1:0] p2_addr,
  input  logic          p2_we,
  input  logic [31:0]   p2_wdata,
  input  logic [3:0]    p2_be,
  output logic          p0_ack,
  output logic          p1_ack,
  output logic          p2_ack,
  output logic [31:0]   rdata,
  output logic [AW:0]   SRAM_ADDR,
  inout  wire  [15:0]   SRAM_DQ,
  output logic          SRAM_CE_N,
  output logic          SRAM_OE_N,
  output logic          SRAM_WE_N,
  output logic          SRAM_UB_N,
  output logic          SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    port_q, port_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;

  logic [2:0]    ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [15:0]   lo_q, lo_d;
  logic [AW:0]   sram_addr_q, sram_addr_d;
  logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic          ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic [15:0]   dq_out_q, dq_out_d;
  logic          dq_oe_q, dq_oe_d;

  logic          p2_wins;

`ifdef SRAM_ARB_RR_EN
  logic last_p2_q;  // 1 when p2 took the most recent p1/p2 grant

  assign p2_wins = p2_req && (!p1_req || !last_p2_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_p2_q <= 1'b0;
    end else if (state_q == IDLE && !p0_req && (p1_req || p2_req)) begin
      last_p2_q <= p2_wins;
    end
  end
`else
  assign p2_wins = p2_req;
`endif

  // State and transaction latch
  always_ff @(posedge clk) begin
    // NOTE: every register, including the latched transaction, is reset so the pins idle cleanly.
    if (!rst) begin
      state_q     <= IDLE;
      port_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      lo_q        <= '0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      lo_q        <= lo_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  // Next state and grant; the request is captured so a dropped req still completes
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    state_d = state_q;
    port_d  = port_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      IDLE: begin
        if (p0_req) begin
          state_d = LO;
          port_d  = 2'd0;
          addr_d  = p0_addr;
          we_d    = 1'b0;
          be_d    = 4'hF;
        end else if (p2_wins) begin
          state_d = LO;
          port_d  = 2'd2;
          addr_d  = p2_addr;
          we_d    = p2_we;
          wdata_d = p2_wdata;
          be_d    = p2_be;
        end else if (p1_req) begin
          state_d = LO;
          port_d  = 2'd1;
          addr_d  = p1_addr;
          we_d    = 1'b0;
          be_d    = 4'hF;
        end
      end
      LO:      state_d = HI;
      HI:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs follow the state being entered
  always_comb begin
    ack_d       = '0;
    sram_addr_d = sram_addr_q;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    lo_d        = (state_q == LO && !we_q) ? SRAM_DQ : lo_q;
    rdata_d     = (state_q == HI && !we_q) ? {SRAM_DQ, lo_q} : rdata_q;
    if (state_d == LO || state_d == HI) begin
      sram_addr_d = {addr_d, state_d == HI};
      ce_n_d      = 1'b0;
      if (we_d) begin
        we_n_d           = 1'b0;
        dq_oe_d          = 1'b1;
        dq_out_d         = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
        {ub_n_d, lb_n_d} = (state_d == HI) ? ~be_d[3:2] : ~be_d[1:0];
      end else begin
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
    end else if (state_d == DONE) begin
      ack_d[port_d] = 1'b1;
    end
  end

  assign p0_ack    = ack_q[0];
  assign p1_ack    = ack_q[1];
  assign p2_ack    = ack_q[2];
  assign rdata     = rdata_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural async SRAM and an ack scoreboard.
module tb_sram_arbiter;
  localparam int AW = 17;
  localparam logic [31:0] D0 = 32'h11112222;  // word 0x20
  localparam logic [31:0] D1 = 32'h33334444;  // word 0x21
  localparam logic [31:0] D2 = 32'h55556666;  // word 0x22

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0, p2_req = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0, p2_addr = '0;
  logic          p2_we = 1'b0;
  logic [31:0]   p2_wdata = '0;
  logic [3:0]    p2_be = 4'hF;
  logic          p0_ack, p1_ack, p2_ack;
  logic [31:0]   rdata;
  logic [AW:0]   SRAM_ADDR;
  wire  [15:0]   SRAM_DQ;
  logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  always #10 clk = ~clk;

  sram_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr),
    .p1_req(p1_req), .p1_addr(p1_addr),
    .p2_req(p2_req), .p2_addr(p2_addr), .p2_we(p2_we), .p2_wdata(p2_wdata), .p2_be(p2_be),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p2_ack(p2_ack), .rdata(rdata),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  // Behavioural SRAM: combinational read, byte-lane writes sampled mid-cycle
  logic [15:0] mem [0:(1 << (AW + 1)) - 1];
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz;

  int we_low_cnt = 0;
  int ce_low_cnt = 0;
  always @(negedge clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  = SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] = SRAM_DQ[15:8];
    end
    if (!SRAM_WE_N) we_low_cnt++;
    if (!SRAM_CE_N) ce_low_cnt++;
  end

  // Scoreboard of expected acks in grant order
  typedef struct packed {
    logic [1:0]  port;
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_rdata = '0;
  logic        rr_last_p2 = 1'b0;

  logic [2:0]  mon_acks;
  exp_t        mon_e;
  logic [31:0] mon_want;

  always @(negedge clk) begin
    mon_acks = {p2_ack, p1_ack, p0_ack};
    if (mon_acks != 3'b000) begin
      n_checks++;
      if (!$onehot(mon_acks)) $display("FAIL ack_onehot: acks=%b, required exactly one", mon_acks);
      else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_ack: acks=%b with nothing outstanding", mon_acks);
      end else begin
        n_pass++;
        mon_e = exp_q.pop_front();
        n_checks++;
        if (mon_acks !== (3'b001 << mon_e.port))
          $display("FAIL sb_port: acks=%b, required port %0d", mon_acks, mon_e.port);
        else n_pass++;
        mon_want = mon_e.is_read ? mon_e.data : last_rdata;
        n_checks++;
        if (rdata !== mon_want) $display("FAIL sb_rdata: rdata=%h, required %h", rdata, mon_want);
        else n_pass++;
        if (mon_e.is_read) last_rdata = mon_e.data;
      end
    end
  end

  function automatic logic [1:0] pick_p1p2();
`ifdef SRAM_ARB_RR_EN
    return rr_last_p2 ? 2'd1 : 2'd2;
`else
    return 2'd2;
`endif
  endfunction

  task automatic push_exp(input logic [1:0] port, input logic is_read, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.is_read = is_read;
    e.data = data;
    exp_q.push_back(e);
    if (port == 2'd1) rr_last_p2 = 1'b0;
    if (port == 2'd2) rr_last_p2 = 1'b1;
  endtask

  task automatic wait_ack(input int port, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if ((port == 0 && p0_ack) || (port == 1 && p1_ack) || (port == 2 && p2_ack)) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Drive one request from a negedge, hold until ack, then leave one cycle so the FSM is IDLE
  task automatic do_access(input int port, input logic [AW-1:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] be, output int cycles);
    case (port)
      0: begin p0_req = 1'b1; p0_addr = addr; end
      1: begin p1_req = 1'b1; p1_addr = addr; end
      default: begin
        p2_req = 1'b1; p2_addr = addr; p2_we = we; p2_wdata = wdata; p2_be = be;
      end
    endcase
    wait_ack(port, cycles);
    p0_req = 1'b0;
    p1_req = 1'b0;
    p2_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({p2_ack, p1_ack, p0_ack} !== 3'b000) $display("FAIL reset_acks: %b, required 000", {p2_ack, p1_ack, p0_ack});
    else n_pass++;
    n_checks++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata: %h, required 0", rdata);
    else n_pass++;
    n_checks++;
    if (SRAM_ADDR !== '0) $display("FAIL reset_addr: %h, required 0", SRAM_ADDR);
    else n_pass++;
    n_checks++;
    if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111)
      $display("FAIL reset_strobes: %b, required 11111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N});
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int c;
    push_exp(2'd2, 1'b0, '0);
    we_low_cnt = 0;
    do_access(2, 17'h00010, 1'b1, 32'hDEADBEEF, 4'hF, c);
    n_checks++;
    if (c !== 3) $display("FAIL write_latency: %0d cycles, required 3", c); else n_pass++;
    n_checks++;
    if (we_low_cnt !== 2) $display("FAIL write_we_cycles: %0d, required 2", we_low_cnt); else n_pass++;
    n_checks++;
    if (mem[18'h00020] !== 16'hBEEF) $display("FAIL write_lo_half: %h, required BEEF", mem[18'h00020]); else n_pass++;
    n_checks++;
    if (mem[18'h00021] !== 16'hDEAD) $display("FAIL write_hi_half: %h, required DEAD", mem[18'h00021]); else n_pass++;
    push_exp(2'd1, 1'b1, 32'hDEADBEEF);
    do_access(1, 17'h00010, 1'b0, '0, 4'hF, c);
    n_checks++;
    if (c !== 3) $display("FAIL read_latency: %0d cycles, required 3", c); else n_pass++;
  endtask

  task automatic test_byte_enables();
    int c;
    push_exp(2'd2, 1'b0, '0);
    do_access(2, 17'h00010, 1'b1, 32'h00AA0000, 4'b0100, c);
    push_exp(2'd1, 1'b1, 32'hDEAABEEF);
    do_access(1, 17'h00010, 1'b0, '0, 4'hF, c);
    push_exp(2'd2, 1'b0, '0);
    we_low_cnt = 0;
    do_access(2, 17'h00010, 1'b1, 32'h12345678, 4'b0000, c);
    n_checks++;
    if (c !== 3) $display("FAIL be0_ack: %0d cycles, required 3", c); else n_pass++;
    n_checks++;
    if (we_low_cnt !== 2) $display("FAIL be0_we_cycles: %0d, required 2", we_low_cnt); else n_pass++;
    push_exp(2'd1, 1'b1, 32'hDEAABEEF);
    do_access(1, 17'h00010, 1'b0, '0, 4'hF, c);
  endtask

  task automatic test_contention();
    int t0 = -1, t1 = -1, t2 = -1;
    int tw, tl;
    logic [1:0] w;
    w = pick_p1p2();
    push_exp(2'd0, 1'b1, D0);
    if (w == 2'd2) begin push_exp(2'd2, 1'b1, D2); push_exp(2'd1, 1'b1, D1); end
    else           begin push_exp(2'd1, 1'b1, D1); push_exp(2'd2, 1'b1, D2); end
    p0_req = 1'b1; p0_addr = 17'h00020;
    p1_req = 1'b1; p1_addr = 17'h00021;
    p2_req = 1'b1; p2_addr = 17'h00022; p2_we = 1'b0;
    for (int i = 1; i <= 40 && (t0 < 0 || t1 < 0 || t2 < 0); i++) begin
      @(negedge clk);
      if (p0_ack) begin t0 = i; p0_req = 1'b0; end
      if (p1_ack) begin t1 = i; p1_req = 1'b0; end
      if (p2_ack) begin t2 = i; p2_req = 1'b0; end
    end
    p0_req = 1'b0; p1_req = 1'b0; p2_req = 1'b0;
    @(negedge clk);
    tw = (w == 2'd2) ? t2 : t1;
    tl = (w == 2'd2) ? t1 : t2;
    n_checks++;
    if (t0 !== 3) $display("FAIL contend_p0: ack at %0d, required 3", t0); else n_pass++;
    n_checks++;
    if (tw !== 7) $display("FAIL contend_winner: p%0d ack at %0d, required 7", w, tw); else n_pass++;
    n_checks++;
    if (tl !== 11) $display("FAIL contend_loser: ack at %0d, required 11", tl); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [9];
    int n = 0, p1_first8 = 0, t_last = -1, exp_p1;
`ifdef SRAM_ARB_RR_EN
    exp_p1 = 4;
`else
    exp_p1 = 0;
`endif
    for (int k = 0; k < 8; k++) begin
      seq[k] = pick_p1p2();
      push_exp(seq[k], 1'b1, (seq[k] == 2'd1) ? D1 : D2);
    end
    seq[8] = (seq[7] == 2'd1) ? 2'd2 : 2'd1;
    push_exp(seq[8], 1'b1, (seq[8] == 2'd1) ? D1 : D2);
    p1_req = 1'b1; p1_addr = 17'h00021;
    p2_req = 1'b1; p2_addr = 17'h00022; p2_we = 1'b0;
    for (int i = 1; i <= 100 && n < 9; i++) begin
      @(negedge clk);
      if (p1_ack || p2_ack) begin
        n++;
        t_last = i;
        if (n <= 8 && p1_ack) p1_first8++;
        if (n >= 8) begin
          if (p1_ack) p1_req = 1'b0;
          if (p2_ack) p2_req = 1'b0;
        end
      end
    end
    p1_req = 1'b0; p2_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (p1_first8 !== exp_p1) $display("FAIL b2b_p1_share: %0d p1 acks in 8, required %0d", p1_first8, exp_p1); else n_pass++;
    n_checks++;
    if (t_last !== 35) $display("FAIL b2b_throughput: 9th ack at %0d, required 35", t_last); else n_pass++;
  endtask

  task automatic test_req_drop();
    int c;
    push_exp(2'd1, 1'b1, D0);
    p1_req = 1'b1; p1_addr = 17'h00020;
    @(negedge clk);
    p1_req = 1'b0;
    wait_ack(1, c);
    if (c > 0) c = c + 1;
    n_checks++;
    if (c !== 3) $display("FAIL drop_ack: ack at %0d, required 3", c); else n_pass++;
    @(negedge clk);
    ce_low_cnt = 0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (ce_low_cnt !== 0) $display("FAIL drop_extra_access: CE_N low %0d cycles, required 0", ce_low_cnt); else n_pass++;
  endtask

  task automatic test_reset_midwrite();
    int c;
    p2_req = 1'b1; p2_addr = 17'h00030; p2_we = 1'b1; p2_wdata = 32'hCAFEF00D; p2_be = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    p2_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({p2_ack, p1_ack, p0_ack} !== 3'b000) $display("FAIL midrst_acks: %b, required 000", {p2_ack, p1_ack, p0_ack});
    else n_pass++;
    n_checks++;
    if (rdata !== 32'h0) $display("FAIL midrst_rdata: %h, required 0", rdata); else n_pass++;
    n_checks++;
    if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111)
      $display("FAIL midrst_strobes: %b, required 11111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N});
    else n_pass++;
    rst = 1'b1;
    last_rdata = '0;
    rr_last_p2 = 1'b0;
    @(negedge clk);
    push_exp(2'd1, 1'b1, D0);
    do_access(1, 17'h00020, 1'b0, '0, 4'hF, c);
    n_checks++;
    if (c !== 3) $display("FAIL postrst_latency: %0d cycles, required 3", c); else n_pass++;
  endtask

  initial begin
    for (int a = 0; a < (1 << (AW + 1)); a++) mem[a] = 16'h0000;
    mem[18'h00040] = D0[15:0]; mem[18'h00041] = D0[31:16];
    mem[18'h00042] = D1[15:0]; mem[18'h00043] = D1[31:16];
    mem[18'h00044] = D2[15:0]; mem[18'h00045] = D2[31:16];
    test_reset();
    test_write_read();
    test_byte_enables();
    test_contention();
    test_back_to_back();
    test_req_drop();
    test_reset_midwrite();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_outstanding: %0d acks missing, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
